// File: rtl/riscv_alu.sv
// RV32I integer ALU: combinational result/zero plus a one-cycle registered copy with valid.
// Optional signed-overflow output enabled by defining RISCV_ALU_OVERFLOW_EN.

package riscv_definitions;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ops_t;
endpackage

module riscv_alu
  import riscv_definitions::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  alu_op,
  input  logic        in_valid,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] result_q,
  output logic        zero_q,
  output logic        valid_q
`ifdef RISCV_ALU_OVERFLOW_EN
  ,
  output logic        overflow
`endif
);

  logic [4:0] shamt;

  assign shamt = operand_b[4:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = operand_a + operand_b;
      ALU_SUB:  result = operand_a - operand_b;
      ALU_AND:  result = operand_a & operand_b;
      ALU_OR:   result = operand_a | operand_b;
      ALU_XOR:  result = operand_a ^ operand_b;
      ALU_SLT:  result = {31'b0, $signed(operand_a) < $signed(operand_b)};
      ALU_SLTU: result = {31'b0, operand_a < operand_b};
      ALU_SLL:  result = operand_a << shamt;
      ALU_SRL:  result = operand_a >> shamt;
      ALU_SRA:  result = $unsigned($signed(operand_a) >>> shamt);
      default:  result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

`ifdef RISCV_ALU_OVERFLOW_EN
  // Signed overflow from operand and result sign bits; carry is never exposed.
  always_comb begin
    overflow = 1'b0;
    case (alu_op)
      ALU_ADD: overflow = (operand_a[31] == operand_b[31]) && (result[31] != operand_a[31]);
      ALU_SUB: overflow = (operand_a[31] != operand_b[31]) && (result[31] != operand_a[31]);
      default: overflow = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result;
        zero_q   <= zero;
      end
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed vector table, reset/registered sequences,
// and randomized operations against an arithmetic reference model.

module tb_riscv_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_op;
  logic        in_valid;
  logic [31:0] result;
  logic        zero;
  logic [31:0] result_q;
  logic        zero_q;
  logic        valid_q;
`ifdef RISCV_ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  riscv_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .alu_op    (alu_op),
    .in_valid  (in_valid),
    .result    (result),
    .zero      (zero),
    .result_q  (result_q),
    .zero_q    (zero_q),
    .valid_q   (valid_q)
`ifdef RISCV_ALU_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: integer arithmetic on widened operands, shifts as multiply/divide by 2^s.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint p  = longint'(1) << b[4:0];
    case (op)
      4'd0: return 32'(ua + ub);
      4'd1: return 32'(ua - ub);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb) ? 32'd1 : 32'd0;
      4'd6: return (ua < ub) ? 32'd1 : 32'd0;
      4'd7: return 32'(ua * p);
      4'd8: return 32'(ua / p);
      4'd9: return (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    if (op == 4'd0) r = sa + sb;
    else if (op == 4'd1) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  vec_t vecs[$];

  initial begin
    logic [31:0] exp_rq;
    logic        exp_zq;
    logic        exp_vq;
    logic [31:0] er;

    vecs.push_back('{4'd0, 32'd10,         32'd15,         32'd25,         1'b0});
    vecs.push_back('{4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0});
    vecs.push_back('{4'd1, 32'd20,         32'd5,          32'd15,         1'b0});
    vecs.push_back('{4'd1, 32'd5,          32'd5,          32'd0,          1'b0});
    vecs.push_back('{4'd0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b1});
    vecs.push_back('{4'd1, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1});
    vecs.push_back('{4'd2, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1'b0});
    vecs.push_back('{4'd3, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'hFF0F_FF0F,  1'b0});
    vecs.push_back('{4'd4, 32'hAA55_AA55,  32'h55AA_55AA,  32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{4'd5, 32'd10,         32'd20,         32'd1,          1'b0});
    vecs.push_back('{4'd5, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0});
    vecs.push_back('{4'd6, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0});
    vecs.push_back('{4'd7, 32'd1,          32'd4,          32'h0000_0010,  1'b0});
    vecs.push_back('{4'd8, 32'hF000_0000,  32'd4,          32'h0F00_0000,  1'b0});
    vecs.push_back('{4'd9, 32'hF000_0000,  32'd4,          32'hFF00_0000,  1'b0});
    vecs.push_back('{4'd7, 32'd1,          32'hFFFF_FF18,  32'h0100_0000,  1'b0});
    vecs.push_back('{4'd9, 32'h8000_0000,  32'd24,         32'hFFFF_FF80,  1'b0});
    vecs.push_back('{4'd9, 32'h8000_0001,  32'h0000_0020,  32'h8000_0001,  1'b0});
    vecs.push_back('{4'd12, 32'h1234_5678, 32'h9ABC_DEF0,  32'd0,          1'b0});
    vecs.push_back('{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd0,          1'b0});

    rst_n = 1'b0;
    in_valid = 1'b0;
    alu_op = 4'd0;
    operand_a = '0;
    operand_b = '0;

    // Directed vectors (combinational path, checked with reset held low).
    foreach (vecs[i]) begin
      @(negedge clk);
      alu_op = vecs[i].op;
      operand_a = vecs[i].a;
      operand_b = vecs[i].b;
      #1;
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp_res == 32'd0));
`ifdef RISCV_ALU_OVERFLOW_EN
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
`endif
    end

    check("rst_result_q", result_q, 32'd0);
    check("rst_zero_q", 32'(zero_q), 32'd1);
    check("rst_valid_q", 32'(valid_q), 32'd0);

    // Release reset and capture ADD 10+15.
    @(negedge clk);
    rst_n = 1'b1;
    alu_op = 4'd0; operand_a = 32'd10; operand_b = 32'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    check("seq1_result_q", result_q, 32'd25);
    check("seq1_zero_q", 32'(zero_q), 32'd0);
    check("seq1_valid_q", 32'(valid_q), 32'd1);

    @(negedge clk);
    alu_op = 4'd1; operand_a = 32'd5; operand_b = 32'd5; in_valid = 1'b0;
    @(posedge clk); #1;
    check("seq2_hold_result_q", result_q, 32'd25);
    check("seq2_hold_zero_q", 32'(zero_q), 32'd0);
    check("seq2_valid_q", 32'(valid_q), 32'd0);

    @(negedge clk);
    alu_op = 4'd4; operand_a = 32'hAAAA_0000; operand_b = 32'h0000_5555; in_valid = 1'b1;
    @(posedge clk); #1;
    check("seq3_result_q", result_q, 32'hAAAA_5555);
    check("seq3_valid_q", 32'(valid_q), 32'd1);

    // Reset asserted between edges clears immediately and discards the in-flight op.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_result_q", result_q, 32'd0);
    check("midrst_zero_q", 32'(zero_q), 32'd1);
    check("midrst_valid_q", 32'(valid_q), 32'd0);
    check("midrst_comb_result", result, 32'hAAAA_5555);
    @(posedge clk); #1;
    check("inrst_result_q", result_q, 32'd0);
    check("inrst_valid_q", 32'(valid_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("postrst_result_q", result_q, 32'd0);
    check("postrst_zero_q", 32'(zero_q), 32'd1);

    // Randomized stream against the reference model.
    exp_rq = 32'd0; exp_zq = 1'b1; exp_vq = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      alu_op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: operand_a = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
        1: operand_a = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
        default: operand_a = $urandom;
      endcase
      operand_b = ($urandom_range(0, 3) == 0) ? operand_a : $urandom;
      in_valid = 1'($urandom_range(0, 1));
      #1;
      er = ref_alu(alu_op, operand_a, operand_b);
      check($sformatf("rnd%0d_op%0d_result", n, alu_op), result, er);
      check($sformatf("rnd%0d_zero", n), 32'(zero), 32'(er == 32'd0));
`ifdef RISCV_ALU_OVERFLOW_EN
      check($sformatf("rnd%0d_ovf", n), 32'(overflow), 32'(ref_ovf(alu_op, operand_a, operand_b)));
`endif
      exp_vq = in_valid;
      if (in_valid) begin
        exp_rq = er;
        exp_zq = (er == 32'd0);
      end
      @(posedge clk); #1;
      check($sformatf("rnd%0d_result_q", n), result_q, exp_rq);
      check($sformatf("rnd%0d_zero_q", n), 32'(zero_q), 32'(exp_zq));
      check($sformatf("rnd%0d_valid_q", n), 32'(valid_q), 32'(exp_vq));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_alu.md
# riscv_alu

Integer ALU for the phanes RV32I core's execute stage: computes ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL and SRA on two 32-bit operands. A zero-latency combinational result feeds forwarding and branch logic. A one-cycle registered copy with a valid flag feeds the writeback pipeline register.

## Interface
- No parameters. Data width is fixed at 32.
- One clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock for the registered stage.
- rst_n  input  1  asynchronous active-low reset.
- operand_a  input  32  first operand (rs1 or PC).
- operand_b  input  32  second operand (rs2 or immediate). Shifts use only bits [4:0].
- alu_op  input  4  operation, type alu_ops_t from riscv_definitions.
- in_valid  input  1  operands and op are valid this cycle.
- result  output  32  combinational result.
- zero  output  1  combinational; 1 when result == 0.
- result_q  output  32  registered result.
- zero_q  output  1  registered zero.
- valid_q  output  1  registered in_valid.
- overflow  output  1  combinational signed overflow; present only when the macro is defined.

## Operation
alu_ops_t encoding:
- ADD=0: a+b, modulo 2^32.
- SUB=1: a−b, modulo 2^32.
- AND=2, OR=3, XOR=4: bitwise.
- SLT=5: signed a<b gives 32'd1, else 0.
- SLTU=6: the same comparison, unsigned.
- SLL=7: a << b[4:0].
- SRL=8: a >> b[4:0], logical.
- SRA=9: $signed(a) >>> b[4:0], sign-filling.
- Codes 10–15: result = 0, so zero = 1.

Rules:
- Carry out of ADD/SUB is discarded.
- Bits [31:5] of operand_b are ignored for shifts. A shift amount of 0 returns a unchanged.
- zero is always derived from result, whatever the op.
- The combinational path has no dependency on clk or rst_n.

## Timing
- result and zero settle combinationally in the same cycle as the inputs.
- On each rising clk with rst_n high:
  - valid_q <= in_valid.
  - When in_valid = 1: result_q <= result and zero_q <= zero.
  - When in_valid = 0: result_q and zero_q hold their previous values.
- Latency of the registered outputs: 1 cycle. There is no backpressure; a new operation can be accepted every cycle.
- Reset (asynchronous assert, synchronous-safe deassert):
  - result_q = 0, zero_q = 1, valid_q = 0, immediately on rst_n falling.
  - Asserting reset mid-operation discards the in-flight result.
  - The first capture occurs on the first rising edge after rst_n rises.
- Combinational outputs are unaffected by reset.

## Configuration
- RISCV_ALU_OVERFLOW_EN defined:
  - The overflow port exists.
  - For ADD: overflow = (a[31]==b[31]) && (result[31]!=a[31]).
  - For SUB: overflow = (a[31]!=b[31]) && (result[31]!=a[31]).
  - For all other ops: overflow = 0.
  - overflow is combinational and unregistered.
- RISCV_ALU_OVERFLOW_EN undefined: the overflow port and its logic are absent. All other behaviour is identical.

## Test plan
- ADD a=10, b=15 -> result=25, zero=0. ADD a=FFFFFFFF, b=1 -> result=0, zero=1.
- SUB a=20, b=5 -> 15. SUB a=5, b=5 -> zero=1. With the macro: ADD a=7FFFFFFF, b=1 -> overflow=1.
- Bitwise ops:
  - AND FF00FF00 & 0F0F0F0F -> 0F000F00.
  - OR of the same operands -> FF0FFF0F.
  - XOR AA55AA55 ^ 55AA55AA -> FFFFFFFF.
- Compares and shifts:
  - SLT 10<20 -> 1. SLT FFFFFFFF<1 -> 1. SLTU FFFFFFFF<1 -> 0.
  - SLL 1 by 4 -> 00000010.
  - SRL F0000000 by 4 -> 0F000000.
  - SRA F0000000 by 4 -> FF000000.
  - Shift with b=24 (b[4:0]=0x18) -> shift by 24.
- Registered path:
  - Hold rst_n low: result_q=0, zero_q=1, valid_q=0.
  - Release reset, drive ADD 10+15 with in_valid=1 -> next edge gives result_q=25, valid_q=1.
  - Next cycle, in_valid=0 with new operands -> result_q stays 25, valid_q=0.
  - Assert rst_n low between edges -> outputs clear immediately.
- Undefined op code 12 -> result=0, zero=1.
